// File: rtl/unidade_controle_if.sv
// unidade_controle_if: ROM fetch bus and datapath stack/temp control bundle
interface unidade_controle_if #(parameter int PROG_AW = 8);
  logic [PROG_AW-1:0] instr_addr;
  logic [20:0] instr_data;
  logic cond;
  logic pilha_en, temp1_en, temp2_en;
  logic wren, controle_pilha, load_temp1, load_temp2;
  logic [15:0] din_UC;
  logic [4:0] opcode;
  modport master (
    output instr_addr, pilha_en, temp1_en, temp2_en, wren, controle_pilha,
           load_temp1, load_temp2, din_UC, opcode,
    input  instr_data, cond
  );
  modport slave (
    input  instr_addr, pilha_en, temp1_en, temp2_en, wren, controle_pilha,
           load_temp1, load_temp2, din_UC, opcode,
    output instr_data, cond
  );
endinterface

// File: rtl/unidade_controle.sv
// unidade_controle: stack-machine controller sequencing fetch/decode/pop/exec over a ROM and datapath stack
module unidade_controle #(
  parameter int PROG_AW = 8,
  parameter int STACK_DEPTH = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic start,
  unidade_controle_if.master bus,
  output logic busy,
  output logic halted,
  output logic erro
);
  localparam int SPW = $clog2(STACK_DEPTH + 1);
  localparam logic [2:0] S_IDLE = 3'd0, S_FETCH = 3'd1, S_DECODE = 3'd2, S_POP1 = 3'd3,
                         S_POP2 = 3'd4, S_EXEC = 3'd5, S_HALT = 3'd6, S_ERRO = 3'd7;
  logic [2:0] state, nxt;
  logic [PROG_AW-1:0] pc;
  logic [SPW-1:0] sp, d_need;
  logic [20:0] ir;
  logic [4:0] d_op, r_op;
  logic d_push, d_err, r_push, r_pop, r_not, r_alu, r_if, in_exec, in_pop1, in_pop2;
  assign d_op = bus.instr_data[20:16];
  assign r_op = ir[20:16];
  assign d_push = d_op == 5'b10000;
  assign d_need = (d_op <= 5'b01000 || (d_op >= 5'b01010 && d_op <= 5'b01110)) ? SPW'(2) :
                  (d_op == 5'b01001 || d_op == 5'b10001) ? SPW'(1) : '0;
  // a full stack on push is reported the same way as an underflow
  assign d_err = sp < d_need || (d_push && sp == SPW'(STACK_DEPTH));
  assign r_push = r_op == 5'b10000;
  assign r_pop = r_op == 5'b10001;
  assign r_not = r_op == 5'b01001;
  assign r_alu = r_op <= 5'b01001;
  assign r_if = r_op >= 5'b01010 && r_op <= 5'b01110;
  assign in_exec = state == S_EXEC;
  assign in_pop1 = state == S_POP1;
  assign in_pop2 = state == S_POP2;
  always_comb
    nxt = state == S_IDLE   ? (start ? S_FETCH : S_IDLE) :
          state == S_FETCH  ? S_DECODE :
          state == S_DECODE ? (d_err ? S_ERRO : d_op == 5'b11111 ? S_HALT : d_push ? S_EXEC :
                               d_need != '0 ? S_POP1 : S_FETCH) :
          state == S_POP1   ? (r_pop ? S_FETCH : r_not ? S_EXEC : S_POP2) :
          state == S_POP2   ? S_EXEC :
          in_exec           ? S_FETCH : state;
  assign bus.instr_addr = pc;
  assign bus.pilha_en = in_pop1 | in_pop2 | (in_exec & (r_push | r_alu));
  assign bus.temp1_en = in_pop1 & ~r_pop;
  assign bus.load_temp1 = in_pop1 & ~r_pop;
  assign bus.temp2_en = in_pop2;
  assign bus.load_temp2 = in_pop2;
  assign bus.wren = in_exec & (r_push | r_alu);
  assign bus.controle_pilha = in_exec & r_alu;
  assign bus.din_UC = (in_exec & r_push) ? ir[15:0] : '0;
  assign bus.opcode = (in_exec & (r_alu | r_if)) ? r_op : '0;
  assign busy = state != S_IDLE && state != S_HALT && state != S_ERRO;
  assign halted = state == S_HALT;
  assign erro = state == S_ERRO;
  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= S_IDLE;
      pc <= '0;
      sp <= '0;
      ir <= '0;
    end else begin
      state <= nxt;
      if (state == S_DECODE) begin
        ir <= bus.instr_data;
        pc <= d_op == 5'b10010 ? bus.instr_data[PROG_AW-1:0] : pc + PROG_AW'(1);
      end
      if (in_exec && r_if && bus.cond) pc <= ir[PROG_AW-1:0];
      if (bus.pilha_en) sp <= bus.wren ? sp + SPW'(1) : sp - SPW'(1);
    end
  end
endmodule

// File: tb/tb_unidade_controle.sv
// tb_unidade_controle: ISA-level trace model vs cycle-sampled controller outputs
module tb_unidade_controle;
  typedef struct packed {
    logic pilha_en, temp1_en, temp2_en, wren, cp, lt1, lt2;
    logic [15:0] din;
    logic [4:0] opcode;
    logic [7:0] addr;
    logic busy, halted, erro;
  } obs_t;
  logic clk = 0, reset = 0, start = 0;
  logic busy, halted, erro;
  logic [20:0] rom [256];
  obs_t exp_q [$];
  int checks = 0, errors = 0, pe_cnt = 0, first_halt = -1;
  unidade_controle_if #(.PROG_AW(8)) bus ();
  unidade_controle #(.PROG_AW(8), .STACK_DEPTH(16)) dut (
    .clk(clk), .reset(reset), .start(start), .bus(bus),
    .busy(busy), .halted(halted), .erro(erro)
  );
  always #5 clk = ~clk;
  always @(posedge clk) bus.instr_data <= rom[bus.instr_addr];

  function automatic logic [20:0] ins(input int op, input int imm);
    return {op[4:0], imm[15:0]};
  endfunction

  function automatic obs_t sample();
    obs_t o;
    o = {bus.pilha_en, bus.temp1_en, bus.temp2_en, bus.wren, bus.controle_pilha,
         bus.load_temp1, bus.load_temp2, bus.din_UC, bus.opcode, bus.instr_addr, busy, halted, erro};
    return o;
  endfunction

  task automatic clear_rom();
    for (int a = 0; a < 256; a++) rom[a] = ins(31, 0);
  endtask

  // Executes the ROM one instruction at a time and lists what each cycle should show
  task automatic build(input int len, input logic c);
    logic [7:0] pc, npc;
    logic [4:0] op;
    logic [15:0] imm;
    int sp, need;
    obs_t e;
    pc = 0;
    sp = 0;
    exp_q.delete();
    while (exp_q.size() < len) begin
      e = '0;
      e.busy = 1;
      e.addr = pc;
      exp_q.push_back(e);
      exp_q.push_back(e);
      {op, imm} = rom[pc];
      npc = pc + 8'd1;
      need = (op <= 8 || (op >= 10 && op <= 14)) ? 2 : (op == 9 || op == 17) ? 1 : 0;
      if (sp < need || (op == 16 && sp == 16) || op == 31) begin
        e = '0;
        e.addr = npc;
        e.halted = op == 31;
        e.erro = op != 31;
        while (exp_q.size() < len) exp_q.push_back(e);
        return;
      end
      if (op == 18) npc = imm[7:0];
      e.addr = npc;
      for (int k = 0; k < need; k++) begin
        obs_t p;
        p = e;
        p.pilha_en = 1;
        if (op != 17) begin
          if (k == 0) {p.temp1_en, p.lt1} = 2'b11;
          else {p.temp2_en, p.lt2} = 2'b11;
        end
        exp_q.push_back(p);
      end
      sp -= need;
      if (op == 16) begin
        e.pilha_en = 1; e.wren = 1; e.din = imm;
        exp_q.push_back(e);
        sp++;
      end else if (op <= 9) begin
        e.pilha_en = 1; e.wren = 1; e.cp = 1; e.opcode = op;
        exp_q.push_back(e);
        sp++;
      end else if (op >= 10 && op <= 14) begin
        e.opcode = op;
        exp_q.push_back(e);
        if (c) npc = imm[7:0];
      end
      pc = npc;
    end
  endtask

  task automatic chk(input obs_t e, input string tag, input int i);
    obs_t o;
    o = sample();
    checks++;
    assert (o === e) else begin
      errors++;
      $error("FAIL %s cyc=%0d got=%h exp=%h", tag, i, o, e);
    end
  endtask

  task automatic run(input int len, input logic c, input int rst_at);
    obs_t o, z;
    z = '0;
    build(len, c);
    bus.cond = c;
    start = 0;
    reset = 0;
    @(negedge clk);
    @(negedge clk);
    chk(z, "reset", -1);
    reset = 1;
    @(negedge clk);
    chk(z, "idle", -1);
    start = 1;
    @(negedge clk);
    pe_cnt = 0;
    first_halt = -1;
    for (int i = 0; i < len; i++) begin
      chk(exp_q[i], "trace", i);
      o = sample();
      pe_cnt += int'(o.pilha_en);
      if (o.halted && first_halt < 0) first_halt = i;
      if (i == rst_at) begin
        reset = 0;
        @(negedge clk);
        chk(z, "mid_reset", i);
        return;
      end
      start = 1'($urandom);
      @(negedge clk);
    end
  endtask

  initial begin
    int ops [20] = '{0, 1, 2, 3, 4, 5, 6, 7, 8, 9, 10, 11, 12, 13, 14, 17, 18, 31, 19, 15};
    bus.cond = 0;
    clear_rom();
    rom[0] = ins(16, 4); rom[1] = ins(16, 2); rom[2] = ins(0, 0); rom[3] = ins(31, 0);
    run(20, 0, -1);
    checks++;
    assert (first_halt === 13) else begin errors++; $error("FAIL halt_at got=%0d exp=13", first_halt); end
    checks++;
    assert (pe_cnt === 5) else begin errors++; $error("FAIL add_pulses got=%0d exp=5", pe_cnt); end
    clear_rom();
    rom[0] = ins(16, 3); rom[1] = ins(16, 3); rom[2] = ins(10, 16'h10); rom[3] = ins(31, 0);
    run(14, 1, -1);
    run(14, 0, -1);
    clear_rom();
    rom[0] = ins(16, 7); rom[1] = ins(0, 0);
    run(12, 1'($urandom), -1);
    clear_rom();
    for (int a = 0; a < 17; a++) rom[a] = ins(16, a + 1);
    run(56, 0, -1);
    checks++;
    assert (pe_cnt === 16) else begin errors++; $error("FAIL overflow_pulses got=%0d exp=16", pe_cnt); end
    clear_rom();
    rom[0] = ins(18, 16'hFF); rom[255] = ins(19, 0);
    run(10, 0, -1);
    clear_rom();
    rom[0] = ins(16, 5); rom[1] = ins(16, 6); rom[2] = ins(2, 0);
    run(20, 0, 9);
    for (int t = 0; t < 8; t++) begin
      for (int a = 0; a < 256; a++)
        rom[a] = ($urandom_range(9) < 4) ? ins(16, int'($urandom)) : ins(ops[$urandom_range(19)], int'($urandom));
      run(80, 1'($urandom), -1);
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/unidade_controle.md
UNIDADE_CONTROLE -- requirements
Module: unidade_controle

Interface
REQ-001 SHALL have parameter PROG_AW, default 8, program-counter/address width.
REQ-002 SHALL have parameter STACK_DEPTH, default 16, datapath stack capacity tracked by controller.
REQ-003 SHALL have port clk  input  1  single system clock; all state changes on rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-low reset.
REQ-005 SHALL have port start  input  1  begins execution from IDLE.
REQ-006 SHALL have port instr_addr  output  PROG_AW  program ROM address, equals pc.
REQ-007 SHALL have port instr_data  input  21  ROM word {opcode[20:16], imm[15:0]}, valid one cycle after instr_addr changes.
REQ-008 SHALL have port cond  input  1  datapath comparator result (ULA data_uc bit 0) for If_* ops.
REQ-009 SHALL have ports pilha_en, temp1_en, temp2_en  output  1 each  one-cycle enable strobes for stack, temp1, temp2.
REQ-010 SHALL have ports wren, controle_pilha, load_temp1, load_temp2  output  1 each  datapath controls; wren=1 push, 0 pop; controle_pilha=1 selects ULA result, 0 selects din_UC.
REQ-011 SHALL have port din_UC  output  16  immediate for push; port opcode  output  5  ULA operation.
REQ-012 SHALL have ports busy, halted, erro  output  1 each  status.

Function
REQ-013 Opcodes SHALL be: Add 00000, Sub 00001, Mul 00010, Div 00011, And 00100, Nand 00101, Or 00110, Xor 00111, Cmp 01000, Not 01001, If_eq 01010, If_gt 01011, If_lt 01100, If_ge 01101, If_le 01110, Push 10000, Pop 10001, Goto 10010, Halt 11111; all others Nop.
REQ-014 States SHALL be IDLE, FETCH, DECODE, POP1, POP2, EXEC, HALT, ERRO.
REQ-015 IDLE -> FETCH when start=1; busy=1 in every state except IDLE, HALT, ERRO.
REQ-016 FETCH: one wait cycle; DECODE: ir <= instr_data, pc <= pc+1 (mod 2^PROG_AW, 0xFF -> 0x00).
REQ-017 Push: DECODE -> EXEC; EXEC drives wren=1, controle_pilha=0, din_UC=imm, pilha_en=1; sp+1; 3 cycles total.
REQ-018 Pop: DECODE -> POP1 with wren=0, pilha_en=1, no temp load; sp-1.
REQ-019 Binary ALU ops (Add..Cmp): POP1 (pilha_en, load_temp1, temp1_en, wren=0) -> POP2 (pilha_en, load_temp2, temp2_en, wren=0) -> EXEC (opcode=ir op, controle_pilha=1, wren=1, pilha_en=1); net sp-1; 5 cycles.
REQ-020 Not: POP1 -> EXEC; net sp unchanged; 4 cycles.
REQ-021 If_*: POP1 -> POP2 -> EXEC with opcode driven, no pilha_en; in EXEC pc <= imm[PROG_AW-1:0] if cond=1; sp-2.
REQ-022 Goto: pc <= imm in DECODE (overrides increment) -> FETCH; Nop: DECODE -> FETCH.
REQ-023 Halt: DECODE -> HALT; halted=1; held until reset, start ignored.
REQ-024 Every strobe SHALL be high exactly one cycle, in its state only; wren, load_temp*, controle_pilha, din_UC, opcode SHALL be stable throughout that cycle; all strobes 0 in IDLE, FETCH, DECODE, HALT, ERRO.
REQ-025 Underflow: op needing n pops with sp<n, or Push with sp=STACK_DEPTH, SHALL go DECODE -> ERRO with no strobe; erro=1 sticky until reset.
REQ-026 sp SHALL range 0..STACK_DEPTH and never wrap.

Reset
REQ-027 reset=0 at a rising edge SHALL, regardless of state: state=IDLE, pc=0, sp=0, ir=0, all strobes and controls 0, din_UC=0, opcode=0, busy=halted=erro=0.
REQ-028 Reset mid-sequence SHALL suppress any pending strobe from the next cycle on.

Verification
REQ-029 ROM {Push 4, Push 2, Add, Halt}, start pulse -> pilha_en pulses with din_UC=0004 then 0002, then POP1/POP2/EXEC with opcode=00000, controle_pilha=1; halted=1 after 14 cycles from start.
REQ-030 {Push 3, Push 3, If_eq imm=0x10} with cond=1 -> no push in EXEC, instr_addr=0x10 next FETCH; cond=0 -> instr_addr=0x03.
REQ-031 Add with sp=1 -> ERRO, erro=1, zero strobes; start ignored until reset.
REQ-032 STACK_DEPTH+1 consecutive Push -> exactly 16 pilha_en pulses, then erro=1.
REQ-033 Goto 0xFF followed by Nop at 0xFF -> next instr_addr 0x00 (wrap).
REQ-034 reset=0 asserted in POP2 of Mul -> next cycle all outputs 0, no EXEC strobe, state IDLE.
